imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: 16-bit LE word count header, then LE 32-bit words.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the last word.
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  i_write,
    output logic [31:0]           i_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic [2:0]            dbg_state_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR0  = 3'd1;
    localparam logic [2:0] S_HDR1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd7;
`endif

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_valid may rise and fall freely, in_ready depends only on state and reset.
    logic [2:0]            state_q, state_d;
    logic [15:0]           n_q, n_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
    logic [23:0]           asm_q, asm_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            csum_q, csum_d;

    logic        accept;
    logic [15:0] hdr_n;
    logic        last_word;

    assign accept    = in_valid && in_ready;
    assign hdr_n     = {in_data, n_q[7:0]};
    assign last_word = (32'(word_idx_q) + 32'd1) >= 32'(n_q);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        asm_d      = asm_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        csum_d     = csum_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_HDR0;
                    byte_cnt_d = 2'd0;
                    word_idx_d = '0;
                    csum_d     = 8'd0;
                end
            end
            S_HDR0: begin
                if (accept) begin
                    n_d[7:0] = in_data;
                    state_d  = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    n_d[15:8] = in_data;
                    if (hdr_n != 16'd0 && {1'b0, hdr_n} <= 17'(DEPTH))
                        state_d = S_DATA;
                    else
                        state_d = S_ERR;
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d     = csum_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    asm_d      = {in_data, asm_q[23:8]};
                    if (byte_cnt_q == 2'd3) begin
                        // Latch the full word and its address so both are stable during WRITE.
                        wdata_d = {in_data, asm_q};
                        addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                state_d = last_word ? S_CSUM : S_DATA;
`else
                state_d = last_word ? S_DONE : S_DATA;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept)
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            n_q        <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_idx_q <= '0;
            asm_q      <= 24'd0;
            wdata_q    <= 32'd0;
            addr_q     <= '0;
            csum_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            asm_q      <= asm_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            csum_q     <= csum_d;
        end
    end

    // Strobes are gated by reset so a pending WRITE is squashed in the cycle reset rises.
`ifdef LOADER_CHECKSUM_EN
    assign in_ready = !reset && (state_q == S_HDR0 || state_q == S_HDR1 ||
                                 state_q == S_DATA || state_q == S_CSUM);
`else
    assign in_ready = !reset && (state_q == S_HDR0 || state_q == S_HDR1 ||
                                 state_q == S_DATA);
`endif
    assign i_write      = !reset && (state_q == S_WRITE);
    assign busy         = !reset && (state_q == S_HDR0 || state_q == S_HDR1 ||
                                     state_q == S_DATA || state_q == S_WRITE);
    assign done         = !reset && (state_q == S_DONE);
    assign error        = !reset && (state_q == S_ERR);
    assign address      = addr_q;
    assign i_data       = wdata_q;
    assign words_loaded = word_idx_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header/data streams, gaps, bad headers, mid-load reset, stray start.
`timescale 1ns/1ps
module tb_imem_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [9:0]  address;
    logic        i_write;
    logic [31:0] i_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] words_loaded;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [9:0]  obs_addr_q[$];
    logic [31:0] obs_data_q[$];
    int          rdy_viol = 0;

    logic [7:0] stream_a [10] = '{8'h02, 8'h00, 8'h13, 8'h0F, 8'h10, 8'h01, 8'h33, 8'h0E, 8'h00, 8'h00};
    logic [7:0] stream_b [6]  = '{8'h01, 8'h00, 8'h13, 8'h0F, 8'h10, 8'h01};

    imem_loader #(.ADDR_WIDTH(10), .DEPTH(1024)) dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .address(address), .i_write(i_write), .i_data(i_data),
        .busy(busy), .done(done), .error(error), .words_loaded(words_loaded),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1);
    end

    // write monitor, sampled mid-cycle
    always @(negedge clock) begin
        if (i_write) begin
            obs_addr_q.push_back(address);
            obs_data_q.push_back(i_data);
            if (in_ready) rdy_viol++;
        end
    end

    // drivers
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  n   = 0;
        bit  acc = 1'b0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!acc && n < 50) begin
            acc = in_ready;
            @(posedge clock); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout: byte %h not accepted, in_ready=%b", b, in_ready);
        end
    endtask

    // Leaves the bench one cycle after the final WRITE, past the checksum byte if present.
    task automatic finish_load(input logic [7:0] csum);
        @(posedge clock); #1;
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum, 1'b0);
`else
        if (csum == 8'hxx) $display("unused");
`endif
    endtask

    task automatic clear_obs();
        obs_addr_q.delete();
        obs_data_q.delete();
        rdy_viol = 0;
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        start = 1'b0;
        total++;
        if ({in_ready, i_write, busy, done, error} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000", {in_ready, i_write, busy, done, error});
        end
        total++;
        if ({address, i_data, words_loaded, dbg_state} !== '0) begin
            bad++; $display("FAIL reset_values: addr=%h data=%h wl=%0d st=%0d want all 0", address, i_data, words_loaded, dbg_state);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        total++;
        if (dbg_state !== 3'd0) begin
            bad++; $display("FAIL reset_idle_hold: state=%0d want 0", dbg_state);
        end
    endtask

    task automatic test_basic();
        clear_obs();
        pulse_start();
        total++;
        if ({busy, in_ready, dbg_state} !== {2'b11, 3'd1}) begin
            bad++; $display("FAIL basic_start: busy=%b rdy=%b st=%0d want 1 1 1", busy, in_ready, dbg_state);
        end
        for (int i = 0; i < 6; i++) send_byte(stream_a[i], 1'b0);
        total++;
        if ({i_write, in_ready, address, i_data} !== {2'b10, 10'd0, 32'h01100F13}) begin
            bad++; $display("FAIL basic_write0: wr=%b rdy=%b addr=%0d data=%h want 1 0 0 01100f13", i_write, in_ready, address, i_data);
        end
        @(posedge clock); #1;
        total++;
        if ({i_write, words_loaded, address} !== {1'b0, 11'd1, 10'd0}) begin
            bad++; $display("FAIL basic_after0: wr=%b wl=%0d addr=%0d want 0 1 0", i_write, words_loaded, address);
        end
        for (int i = 6; i < 10; i++) send_byte(stream_a[i], 1'b0);
        total++;
        if ({i_write, address, i_data} !== {1'b1, 10'd1, 32'h00000E33}) begin
            bad++; $display("FAIL basic_write1: wr=%b addr=%0d data=%h want 1 1 00000e33", i_write, address, i_data);
        end
        finish_load(8'h30);
        total++;
        if ({done, busy, error, words_loaded} !== {3'b100, 11'd2}) begin
            bad++; $display("FAIL basic_done: done=%b busy=%b err=%b wl=%0d want 1 0 0 2", done, busy, error, words_loaded);
        end
        total++;
        if (obs_addr_q.size() != 2) begin
            bad++; $display("FAIL basic_count: writes=%0d want 2", obs_addr_q.size());
        end
    endtask

    task automatic test_gaps();
        clear_obs();
        pulse_start();
        total++;
        if ({done, words_loaded} !== 12'd0) begin
            bad++; $display("FAIL gaps_restart_clear: done=%b wl=%0d want 0 0", done, words_loaded);
        end
        for (int i = 0; i < 10; i++) send_byte(stream_a[i], 1'b1);
        finish_load(8'h30);
        total++;
        if (obs_addr_q.size() != 2 || obs_addr_q[0] !== 10'd0 || obs_data_q[0] !== 32'h01100F13 ||
            obs_addr_q[1] !== 10'd1 || obs_data_q[1] !== 32'h00000E33) begin
            bad++; $display("FAIL gaps_writes: n=%0d got %p %p want [0,1] [01100f13,00000e33]", obs_addr_q.size(), obs_addr_q, obs_data_q);
        end
        total++;
        if (rdy_viol != 0) begin
            bad++; $display("FAIL gaps_ready_in_write: violations=%0d want 0", rdy_viol);
        end
        total++;
        if ({done, words_loaded} !== {1'b1, 11'd2}) begin
            bad++; $display("FAIL gaps_done: done=%b wl=%0d want 1 2", done, words_loaded);
        end
    endtask

    task automatic test_bad_header();
        clear_obs();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        total++;
        if ({error, done, busy, in_ready, dbg_state} !== {4'b1000, 3'd6}) begin
            bad++; $display("FAIL hdr_zero: err=%b done=%b busy=%b rdy=%b st=%0d want 1 0 0 0 6", error, done, busy, in_ready, dbg_state);
        end
        pulse_start();
        total++;
        if ({error, busy} !== 2'b01) begin
            bad++; $display("FAIL hdr_restart: err=%b busy=%b want 0 1", error, busy);
        end
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        total++;
        if ({error, dbg_state} !== {1'b1, 3'd6}) begin
            bad++; $display("FAIL hdr_1025: err=%b st=%0d want 1 6", error, dbg_state);
        end
        total++;
        if (obs_addr_q.size() != 0) begin
            bad++; $display("FAIL hdr_no_write: writes=%0d want 0", obs_addr_q.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(stream_b[i], 1'b0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        total++;
        if ({in_ready, i_write, busy, done, error, address, i_data, words_loaded, dbg_state} !== '0) begin
            bad++; $display("FAIL rstmid_values: rdy=%b wr=%b busy=%b addr=%h data=%h wl=%0d st=%0d want all 0",
                            in_ready, i_write, busy, address, i_data, words_loaded, dbg_state);
        end
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(stream_b[i], 1'b0);
        reset = 1'b1;
        #1;
        total++;
        if (i_write !== 1'b0) begin
            bad++; $display("FAIL rstmid_squash: wr=%b want 0", i_write);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        total++;
        if (obs_addr_q.size() != 0) begin
            bad++; $display("FAIL rstmid_no_write: writes=%0d want 0", obs_addr_q.size());
        end
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(stream_a[i], 1'b0);
        finish_load(8'h30);
        total++;
        if (!done || obs_addr_q.size() != 2 || obs_data_q[0] !== 32'h01100F13 || obs_data_q[1] !== 32'h00000E33) begin
            bad++; $display("FAIL rstmid_reload: done=%b n=%0d data=%p want 1 2 [01100f13,00000e33]", done, obs_addr_q.size(), obs_data_q);
        end
    endtask

    task automatic test_start_busy();
        clear_obs();
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(stream_a[i], 1'b0);
        pulse_start();
        repeat (20) @(posedge clock);
        #1;
        total++;
        if ({busy, dbg_state, words_loaded} !== {1'b1, 3'd3, 11'd0}) begin
            bad++; $display("FAIL busy_start_ignored: busy=%b st=%0d wl=%0d want 1 3 0", busy, dbg_state, words_loaded);
        end
        for (int i = 3; i < 10; i++) send_byte(stream_a[i], 1'b0);
        finish_load(8'h30);
        total++;
        if (!done || words_loaded !== 11'd2 || obs_addr_q.size() != 2 ||
            obs_addr_q[1] !== 10'd1 || obs_data_q[0] !== 32'h01100F13 || obs_data_q[1] !== 32'h00000E33) begin
            bad++; $display("FAIL busy_load: done=%b wl=%0d n=%0d data=%p want 1 2 2 [01100f13,00000e33]", done, words_loaded, obs_addr_q.size(), obs_data_q);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        // XOR of 13 0F 10 01 is 0D
        clear_obs();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(stream_b[i], 1'b0);
        @(posedge clock); #1;
        total++;
        if ({in_ready, busy, dbg_state} !== {2'b10, 3'd7}) begin
            bad++; $display("FAIL csum_state: rdy=%b busy=%b st=%0d want 1 0 7", in_ready, busy, dbg_state);
        end
        send_byte(8'h0D, 1'b0);
        total++;
        if ({done, error} !== 2'b10 || obs_addr_q.size() != 1 || obs_addr_q[0] !== 10'd0 || obs_data_q[0] !== 32'h01100F13) begin
            bad++; $display("FAIL csum_good: done=%b err=%b n=%0d data=%p want 1 0 1 [01100f13]", done, error, obs_addr_q.size(), obs_data_q);
        end
        clear_obs();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(stream_b[i], 1'b0);
        finish_load(8'h00);
        total++;
        if ({done, error} !== 2'b01 || obs_addr_q.size() != 1 || obs_data_q[0] !== 32'h01100F13) begin
            bad++; $display("FAIL csum_bad: done=%b err=%b n=%0d data=%p want 0 1 1 [01100f13]", done, error, obs_addr_q.size(), obs_data_q);
        end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_basic();
        test_gaps();
        test_bad_header();
        test_reset_mid();
        test_start_busy();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
